// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed common-anode seven-segment driver.
// A loaded value waits in a pending register. It is copied into the
// displayed (shadow) register only at a frame boundary, so a frame never
// mixes old and new digits. Seg, Dig and Frame are all registered.
module seg7_scan #(
  parameter int DIV      = 12500,  // clocks per digit slot (>= 4)
  parameter int GUARD    = 4,      // all-digits-off cycles at slot start
  parameter bit BLANK_LZ = 1'b1    // 1 = blank leading zero digits
) (
  input  logic        C,
  input  logic        R,
  input  logic [15:0] D,
  input  logic [3:0]  DP,
  input  logic        Load,
  output logic [7:0]  Seg,
  output logic [3:0]  Dig,
  output logic        Frame
);

  localparam int            CW       = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_CW = CW'(GUARD);

  // Hex nibble to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_v_q, pend_v_d;
  logic [15:0]   shad_val_q, shad_val_d;
  logic [3:0]    shad_dp_q, shad_dp_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          frame_q, frame_d;

  logic          slot_end_s;
  logic          frame_end_s;
  logic [3:0]    nib_s;
  logic          blank_s;
  logic          dp_s;

  // Slot and frame boundary detection from the current scan position.
  always_comb begin
    slot_end_s  = (cnt_q == CNT_MAX);
    frame_end_s = slot_end_s && (idx_q == 2'd3);
  end

  // Prescaler and slot index advance.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end_s) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
    end
  end

  // Pending capture and frame-boundary transfer into the shadow register;
  // a load on the boundary edge itself bypasses straight to the shadow.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_v_d   = pend_v_q;
    shad_val_d = shad_val_q;
    shad_dp_d  = shad_dp_q;
    if (Load) begin
      pend_val_d = D;
      pend_dp_d  = DP;
      pend_v_d   = 1'b1;
    end else begin
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
    end
    if (frame_end_s) begin
      pend_v_d = 1'b0;
      if (Load) begin
        shad_val_d = D;
        shad_dp_d  = DP;
      end else if (pend_v_q) begin
        shad_val_d = pend_val_q;
        shad_dp_d  = pend_dp_q;
      end else begin
        shad_val_d = shad_val_q;
        shad_dp_d  = shad_dp_q;
      end
    end else begin
      shad_val_d = shad_val_q;
      shad_dp_d  = shad_dp_q;
    end
  end

  // Select the nibble for the active slot and decide leading-zero blanking.
  always_comb begin
    nib_s   = 4'h0;
    blank_s = 1'b0;
    case (idx_q)
      2'd0: begin
        nib_s   = shad_val_q[3:0];
        blank_s = 1'b0;
      end
      2'd1: begin
        nib_s   = shad_val_q[7:4];
        blank_s = (shad_val_q[15:4] == 12'h000);
      end
      2'd2: begin
        nib_s   = shad_val_q[11:8];
        blank_s = (shad_val_q[15:8] == 8'h00);
      end
      2'd3: begin
        nib_s   = shad_val_q[15:12];
        blank_s = (shad_val_q[15:12] == 4'h0);
      end
      default: begin
        nib_s   = 4'h0;
        blank_s = 1'b0;
      end
    endcase
    blank_s = blank_s && (BLANK_LZ != 1'b0);
    dp_s    = shad_dp_q[idx_q];
  end

  // Next values of the registered display outputs.
  always_comb begin
    seg_d   = {~dp_s, (blank_s ? 7'h7F : hex_to_seg(nib_s))};
    dig_d   = 4'hF;
    if (cnt_q < GUARD_CW) begin
      dig_d = 4'hF;
    end else begin
      dig_d = ~(4'b0001 << idx_q);
    end
    frame_d = frame_end_s;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      pend_v_q   <= 1'b0;
      shad_val_q <= 16'h0000;
      shad_dp_q  <= 4'h0;
      seg_q      <= 8'hFF;
      dig_q      <= 4'hF;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_v_q   <= pend_v_d;
      shad_val_q <= shad_val_d;
      shad_dp_q  <= shad_dp_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
      frame_q    <= frame_d;
    end
  end

  assign Seg   = seg_q;
  assign Dig   = dig_q;
  assign Frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (leading-zero blanking on and off)
// driven by the same directed stimulus, compared every cycle against a
// frame-position model, plus hand-computed digit expectations.
module tb_seg7_scan;

  localparam int P_DIV   = 8;
  localparam int P_GUARD = 2;
  localparam int P_FRAME = 4 * P_DIV;

  localparam logic [7:0] HEX_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        c = 1'b0;
  logic        r;
  logic [15:0] d;
  logic [3:0]  dp;
  logic        load;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;
  logic        frame_a, frame_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: position in frame, displayed value, pending value.
  int          m_pos;
  logic [15:0] m_sv, m_pv;
  logic [3:0]  m_sd, m_pd;
  bit          m_pendv;

  seg7_scan #(.DIV(P_DIV), .GUARD(P_GUARD), .BLANK_LZ(1'b1)) dut_a (
    .C(c), .R(r), .D(d), .DP(dp), .Load(load),
    .Seg(seg_a), .Dig(dig_a), .Frame(frame_a)
  );

  seg7_scan #(.DIV(P_DIV), .GUARD(P_GUARD), .BLANK_LZ(1'b0)) dut_b (
    .C(c), .R(r), .D(d), .DP(dp), .Load(load),
    .Seg(seg_b), .Dig(dig_b), .Frame(frame_b)
  );

  always #5 c = ~c;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Expected segments: digit at position, blank if value has no nonzero
  // nibble at or above this slot (slot 0 never blank).
  function automatic logic [7:0] exp_seg(input int pos, input logic [15:0] v,
                                         input logic [3:0] p, input bit blank);
    int         slot;
    logic [7:0] t;
    slot = pos / P_DIV;
    t = HEX_TAB[int'((v >> (4 * slot)) & 16'h000F)];
    if (blank && slot > 0 && (v >> (4 * slot)) == 16'h0000) t = 8'hFF;
    t[7] = ~p[slot];
    return t;
  endfunction

  function automatic logic [3:0] exp_dig(input int pos);
    logic [3:0] m;
    m = 4'b0001 << (pos / P_DIV);
    if ((pos % P_DIV) < P_GUARD) return 4'hF;
    return ~m;
  endfunction

  // Per-cycle compare process: expected outputs after an edge come from the
  // model state before that edge; then the model takes the edge.
  initial begin
    logic [7:0] e_sa, e_sb;
    logic [3:0] e_dig;
    logic       e_fr;
    forever begin
      @(posedge c);
      if (r) begin
        m_pos = 0; m_sv = 16'h0; m_sd = 4'h0; m_pv = 16'h0; m_pd = 4'h0; m_pendv = 0;
        e_sa = 8'hFF; e_sb = 8'hFF; e_dig = 4'hF; e_fr = 1'b0;
      end else begin
        e_sa  = exp_seg(m_pos, m_sv, m_sd, 1'b1);
        e_sb  = exp_seg(m_pos, m_sv, m_sd, 1'b0);
        e_dig = exp_dig(m_pos);
        e_fr  = (m_pos == P_FRAME - 1);
        if (m_pos == P_FRAME - 1) begin
          if (load) begin
            m_sv = d; m_sd = dp;
          end else if (m_pendv) begin
            m_sv = m_pv; m_sd = m_pd;
          end
          m_pendv = 0;
        end else if (load) begin
          m_pv = d; m_pd = dp; m_pendv = 1;
        end
        m_pos = (m_pos + 1) % P_FRAME;
      end
      #1;
      check("cyc_seg_blank", seg_a, e_sa);
      check("cyc_seg_noblank", seg_b, e_sb);
      check("cyc_dig_a", {4'h0, dig_a}, {4'h0, e_dig});
      check("cyc_dig_b", {4'h0, dig_b}, {4'h0, e_dig});
      check("cyc_frame", {7'h0, frame_a}, {7'h0, e_fr});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge c);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    @(negedge c);
    d = v; dp = p; load = 1'b1;
    @(negedge c);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int k = 0;
    do begin
      @(negedge c);
      k++;
    end while (frame_a !== 1'b1 && k < 80);
    if (frame_a !== 1'b1) timeout("wait_frame");
  endtask

  task automatic wait_dig(input int idx);
    int         k = 0;
    logic [3:0] m;
    m = ~(4'b0001 << idx);
    do begin
      @(negedge c);
      k++;
    end while (dig_a !== m && k < 80);
    if (dig_a !== m) timeout("wait_dig");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with hand-computed digit expectations.
  initial begin
    r = 1'b1; load = 1'b0; d = 16'h0; dp = 4'h0;
    cyc(3);
    check("reset_seg", seg_a, 8'hFF);
    check("reset_dig", {4'h0, dig_a}, 8'h0F);
    check("reset_frame", {7'h0, frame_a}, 8'h00);
    r = 1'b0;
    @(negedge c); check("guard0_dig", {4'h0, dig_a}, 8'h0F);
    @(negedge c); check("guard1_dig", {4'h0, dig_a}, 8'h0F);
    @(negedge c); check("slot0_dig", {4'h0, dig_a}, 8'h0E);
    check("slot0_seg", seg_a, 8'hC0);
    wait_dig(1); check("rst_d1", seg_a, 8'hFF);
    wait_dig(2); check("rst_d2", seg_a, 8'hFF);
    wait_dig(3); check("rst_d3", seg_a, 8'hFF);

    // Mid-frame load only shows from the next frame
    wait_frame(); cyc(10);
    do_load(16'h12AF, 4'h0);
    wait_dig(2); check("old_d2", seg_a, 8'hFF);
    wait_frame();
    wait_dig(0); check("t2_d0", seg_a, 8'h8E);
    wait_dig(1); check("t2_d1", seg_a, 8'h88);
    wait_dig(2); check("t2_d2", seg_a, 8'hA4);
    wait_dig(3); check("t2_d3", seg_a, 8'hF9);

    // Leading-zero blanking on and off
    do_load(16'h0030, 4'h0);
    wait_frame();
    wait_dig(0); check("t3_d0_a", seg_a, 8'hC0); check("t3_d0_b", seg_b, 8'hC0);
    wait_dig(1); check("t3_d1_a", seg_a, 8'hB0); check("t3_d1_b", seg_b, 8'hB0);
    wait_dig(2); check("t3_d2_a", seg_a, 8'hFF); check("t3_d2_b", seg_b, 8'hC0);
    wait_dig(3); check("t3_d3_a", seg_a, 8'hFF); check("t3_d3_b", seg_b, 8'hC0);

    // Decimal points on zero and on a blanked digit
    do_load(16'h0000, 4'b1001);
    wait_frame();
    wait_dig(0); check("t4_d0", seg_a, 8'h40);
    wait_dig(1); check("t4_d1", seg_a, 8'hFF);
    wait_dig(2); check("t4_d2", seg_a, 8'hFF);
    wait_dig(3); check("t4_d3", seg_a, 8'h7F); check("t4_d3_b", seg_b, 8'h40);

    // Two loads in one frame: last one wins
    wait_frame(); cyc(4);
    do_load(16'h1111, 4'h0); cyc(4);
    do_load(16'h2222, 4'h0);
    wait_frame();
    wait_dig(0); check("t5_d0", seg_a, 8'hA4);
    wait_dig(3); check("t5_d3", seg_a, 8'hA4);

    // Load exactly on the boundary edge bypasses to the display
    wait_frame(); cyc(30);
    do_load(16'h3333, 4'h0);
    check("t5_bypass_frame", {7'h0, frame_a}, 8'h01);
    wait_dig(0); check("t5_bypass_d0", seg_a, 8'hB0);
    wait_frame();
    wait_dig(0); check("t5_hold_d0", seg_a, 8'hB0);

    // Asynchronous reset mid-slot discards a pending load
    cyc(5);
    do_load(16'h4444, 4'h0);
    @(negedge c); #1 r = 1'b1;
    #1;
    check("t6_async_seg", seg_a, 8'hFF);
    check("t6_async_dig", {4'h0, dig_a}, 8'h0F);
    check("t6_async_frame", {7'h0, frame_a}, 8'h00);
    cyc(3);
    r = 1'b0;
    wait_frame(); wait_frame();
    wait_dig(0); check("t6_d0", seg_a, 8'hC0);
    wait_dig(1); check("t6_d1", seg_a, 8'hFF);
    wait_dig(3); check("t6_d3", seg_a, 8'hFF);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Four-digit multiplexed seven-segment display driver for the EP4CE6E22C8 board. Accepts a 16-bit hexadecimal value plus decimal points through a load strobe and scans it onto common-anode digits with active-low segment and digit outputs. New values are applied only at frame boundaries, so the display never shows a mix of old and new digits. It sits downstream of the board counters and is the display-side consumer of their count values.

## Interface
- DIV, 12500: clocks per digit slot; 50 MHz gives a 4 kHz slot rate and a 1 kHz frame rate; must be ≥ 4.
- GUARD, 4: cycles at the start of each slot with all digits off (anti-ghosting); 1 ≤ GUARD < DIV.
- BLANK_LZ, 1: 1 = blank leading zero digits.
- C  input  1  clock; all state is rising-edge.
- R  input  1  reset, asynchronous and active-high.
- D  input  16  value to display; D[3:0] is the rightmost digit (digit 0).
- DP  input  4  decimal point per digit; 1 = lit.
- Load  input  1  capture D/DP on this edge.
- Seg  output  8  segments, active-low, order {dp,g,f,e,d,c,b,a}.
- Dig  output  4  digit enables, active-low, one-hot-low.
- Frame  output  1  one-cycle pulse at each frame boundary.

## Operation
- Prescaler `cnt` runs 0..DIV-1 and wraps. At the slot end (`cnt==DIV-1`), slot index `idx` advances 0→1→2→3→0.
- **Frame boundary:** the edge where `cnt==DIV-1` and `idx==3`.
- **Pending register:**
  - `Load` at any edge writes D/DP into the pending register and sets `pend_v`.
  - If several loads occur in one frame, the last one wins.
- **Shadow register** (the displayed value):
  - At a frame boundary, shadow ← pending when `pend_v` is set, and `pend_v` clears.
  - If `Load` is asserted on the boundary edge itself, shadow ← D/DP directly (bypass), and `pend_v` is left clear.
- **Hex decode, active-low with dp=1 (off):**
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- **Decimal point:** Seg[7] = !DP[idx], taken from the shadow DP bits.
- **Leading-zero blank** (BLANK_LZ=1):
  - Digit 3 is blank if nibble 3 is 0.
  - Digit 2 is blank if nibbles 3 and 2 are 0.
  - Digit 1 is blank if nibbles 3..1 are 0.
  - Digit 0 is never blank.
  - A blank digit drives Seg[6:0]=7F. Its dp still follows DP.
- **Digit enable:**
  - Dig[idx]=0 when `cnt ≥ GUARD`.
  - All Dig=1 when `cnt < GUARD`.

## Timing
- Seg, Dig and Frame are registered. The values after edge n+1 are computed from `cnt`, `idx` and shadow as they stand after edge n (one-cycle lag).
- Frame is high for exactly the one cycle following the registered update of the boundary edge.
- Frame period is 4·DIV cycles. Each digit is lit for DIV−GUARD cycles per frame.
- Load-to-display latency: from 1 cycle up to one full frame plus 1 cycle.
- Reset, applied immediately without waiting for a clock edge:
  - `cnt`=0, `idx`=0.
  - Pending and shadow = 0; `pend_v`=0.
  - Seg=FF, Dig=F, Frame=0.
- Reset mid-frame discards any pending load.
- After release the display shows "   0" (blanking enabled), starting in slot 0.
- Load and reset together: reset wins.

## Test plan
All scenarios use DIV=8, GUARD=2 (frame = 32 cycles).

1. Hold R, then release → while R is high Seg=FF, Dig=F. After release, Dig stays F for the guard cycles, then Dig=E with Seg=C0. Digits 1..3 show Seg=FF while enabled.
2. Mid-frame Load with D=0x12AF, DP=0 → display unchanged until Frame pulses; from the next frame digit0=8E, digit1=88, digit2=A4, digit3=F9.
3. D=0x0030 with BLANK_LZ=1 → digit3=FF, digit2=FF, digit1=B0, digit0=C0. Same with BLANK_LZ=0 → digit3=C0, digit2=C0.
4. D=0x0000 with DP=4'b1001 → digit0=40, digit3=7F (blank with dp lit), digits 1 and 2 = FF.
5. Two loads in one frame, 0x1111 then 0x2222 → only 2222 appears (digits A4). A Load of 0x3333 on the boundary edge → B0 shows in the very next slot.
6. Assert R mid-slot between clock edges → Seg=FF, Dig=F, Frame=0 immediately. A load pending before reset is never displayed.
